// File: rtl/video_timing_pattern_gen_pkg.sv
//==============================================================================
// Module  : video_timing_pattern_gen_pkg
// Brief   : Shared pattern-mode codes, colour-bar table and raster length helper.
// Revision: 1.0
//==============================================================================
`default_nettype none

package video_timing_pattern_gen_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_mode_t;

    // Bar colours as {r,g,b} full-scale flags, expanded to PIX_W at the top level
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

    function automatic int total_len(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_timing_counter.sv
//==============================================================================
// Module  : video_timing_counter
// Brief   : Raster h/v counters with de/sync/marker strobes for the current position.
// Revision: 1.0
//==============================================================================
`default_nettype none

module video_timing_counter
    import video_timing_pattern_gen_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int H_RES  = 64,
    parameter int H_FP   = 8,
    parameter int H_SYNC = 2,
    parameter int H_BP   = 8,
    parameter int V_RES  = 64,
    parameter int V_FP   = 8,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 8
) (
    input  logic             hdmi_clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             de,
    output logic             hs_act,
    output logic             vs_act,
    output logic             sof,
    output logic             eol,
    output logic             frame_wrap
);

    localparam int HT = total_len(H_RES, H_FP, H_SYNC, H_BP);
    localparam int VT = total_len(V_RES, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] H_EOL    = CNT_W'(H_RES - 1);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_RES + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_RES + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_RES + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_RES + V_FP + V_SYNC);

    logic h_last;
    logic v_last;

    assign h_last = (hcnt == H_LAST);
    assign v_last = (vcnt == V_LAST);

    // Disabling parks the raster at (0,0) so re-enabling restarts a clean frame
    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    assign de         = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_act     = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_act     = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign sof        = (hcnt == '0) && (vcnt == '0);
    assign eol        = de && (hcnt == H_EOL);
    assign frame_wrap = h_last && v_last;

endmodule

`default_nettype wire

// File: rtl/video_timing_pattern_gen.sv
//==============================================================================
// Module  : video_timing_pattern_gen
// Brief   : HDMI/DVI raster timing source with selectable built-in test pattern.
// Revision: 1.0
//==============================================================================
`default_nettype none

module video_timing_pattern_gen
    import video_timing_pattern_gen_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int CNT_W    = 12,
    parameter int H_RES    = 64,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 2,
    parameter int H_BP     = 8,
    parameter int V_RES    = 64,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 8,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CHK_LOG2 = 3,
    parameter int FCNT_W   = 16
) (
    input  logic               hdmi_clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [3*PIX_W-1:0] solid_rgb,
    output logic               hdmi_de,
    output logic               hdmi_hs,
    output logic               hdmi_vs,
    output logic [PIX_W-1:0]   hdmi_r,
    output logic [PIX_W-1:0]   hdmi_g,
    output logic [PIX_W-1:0]   hdmi_b,
    output logic               sof,
    output logic               eol,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam int BAR_W = H_RES / 8;

    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   vcnt;
    logic               pos_de;
    logic               pos_hs;
    logic               pos_vs;
    logic               pos_sof;
    logic               pos_eol;
    logic               frame_wrap;
    pat_mode_t          mode_q;
    logic [3*PIX_W-1:0] solid_q;
    pat_mode_t          mode_cur;
    logic [3*PIX_W-1:0] solid_cur;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_flags;
    logic [3*PIX_W-1:0] pix;
    logic               unused_vcnt;

    video_timing_counter #(
        .CNT_W  (CNT_W),
        .H_RES  (H_RES),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_RES  (V_RES),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_counter (
        .hdmi_clk   (hdmi_clk),
        .rst        (rst),
        .en         (en),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .de         (pos_de),
        .hs_act     (pos_hs),
        .vs_act     (pos_vs),
        .sof        (pos_sof),
        .eol        (pos_eol),
        .frame_wrap (frame_wrap)
    );

    assign unused_vcnt = ^vcnt;

    // Pixel (0,0) already uses the freshly sampled mode; the rest of the frame uses the held copy
    assign mode_cur  = pos_sof ? pat_mode_t'(mode) : mode_q;
    assign solid_cur = pos_sof ? solid_rgb : solid_q;

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hcnt >= CNT_W'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign bar_flags = bar_rgb(bar_idx);

    always_comb begin
        pix = '0;
        case (mode_cur)
            PAT_SOLID: pix = solid_cur;
            PAT_BARS:  pix = {{PIX_W{bar_flags[2]}}, {PIX_W{bar_flags[1]}}, {PIX_W{bar_flags[0]}}};
            PAT_RAMP:  pix = {3{hcnt[PIX_W-1:0]}};
            PAT_CHECK: pix = {3*PIX_W{hcnt[CHK_LOG2] ~^ vcnt[CHK_LOG2]}};
            default:   pix = '0;
        endcase
        if (!pos_de) begin
            pix = '0;
        end
    end

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            hdmi_de                  <= 1'b0;
            hdmi_hs                  <= ~HS_POL;
            hdmi_vs                  <= ~VS_POL;
            {hdmi_r, hdmi_g, hdmi_b} <= '0;
            sof                      <= 1'b0;
            eol                      <= 1'b0;
            frame_cnt                <= '0;
            mode_q                   <= PAT_SOLID;
            solid_q                  <= '0;
        end else if (!en) begin
            hdmi_de                  <= 1'b0;
            hdmi_hs                  <= ~HS_POL;
            hdmi_vs                  <= ~VS_POL;
            {hdmi_r, hdmi_g, hdmi_b} <= '0;
            sof                      <= 1'b0;
            eol                      <= 1'b0;
        end else begin
            hdmi_de                  <= pos_de;
            hdmi_hs                  <= pos_hs ? HS_POL : ~HS_POL;
            hdmi_vs                  <= pos_vs ? VS_POL : ~VS_POL;
            {hdmi_r, hdmi_g, hdmi_b} <= pix;
            sof                      <= pos_sof;
            eol                      <= pos_eol;
            if (pos_sof) begin
                mode_q  <= pat_mode_t'(mode);
                solid_q <= solid_rgb;
            end
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_pattern_gen.sv
//==============================================================================
// Module  : tb_video_timing_pattern_gen
// Brief   : Directed self-checking bench on a 14x7 raster, both sync polarities.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_video_timing_pattern_gen;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] solid;

    logic        de, hs, vs, sof, eol;
    logic [7:0]  r, g, b;
    logic [15:0] fc;
    logic        p_de, p_hs, p_vs, p_sof, p_eol;
    logic [7:0]  p_r, p_g, p_b;
    logic [15:0] p_fc;

    int n_checks = 0;
    int n_pass   = 0;
    int pos      = 0;
    int exp_fc   = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .PIX_W(8), .CNT_W(12), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
        .CHK_LOG2(1), .FCNT_W(16)
    ) dut (
        .hdmi_clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
        .hdmi_de(de), .hdmi_hs(hs), .hdmi_vs(vs), .hdmi_r(r), .hdmi_g(g), .hdmi_b(b),
        .sof(sof), .eol(eol), .frame_cnt(fc)
    );

    video_timing_pattern_gen #(
        .PIX_W(8), .CNT_W(12), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
        .CHK_LOG2(1), .FCNT_W(16)
    ) dut_p (
        .hdmi_clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
        .hdmi_de(p_de), .hdmi_hs(p_hs), .hdmi_vs(p_vs), .hdmi_r(p_r), .hdmi_g(p_g), .hdmi_b(p_b),
        .sof(p_sof), .eol(p_eol), .frame_cnt(p_fc)
    );

    // {de, hs_active, vs_active, sof, eol} for raster position p
    function automatic logic [4:0] exp_tim(input int p);
        int  h;
        int  v;
        logic d;
        h = p % HT;
        v = p / HT;
        d = (h < 8) && (v < 4);
        return {d, (h == 10) || (h == 11), v == 5, p == 0, d && (h == 7)};
    endfunction

    function automatic logic [23:0] exp_pix(input int p, input logic [1:0] m, input logic [23:0] s);
        int         h;
        int         v;
        logic [7:0] hb;
        h  = p % HT;
        v  = p / HT;
        hb = 8'(h);
        if (!((h < 8) && (v < 4))) return 24'h0;
        case (m)
            2'd0:    return s;
            2'd1:    return bars[h];
            2'd2:    return {hb, hb, hb};
            default: return ((((h >> 1) ^ (v >> 1)) & 1) == 0) ? 24'hFFFFFF : 24'h0;
        endcase
    endfunction

    task automatic step();
        logic act;
        act = en && !rst;
        @(posedge clk);
        #1;
        if (act) begin
            if (pos == FT - 1) exp_fc = (exp_fc + 1) % 65536;
            pos = (pos + 1) % FT;
        end else begin
            pos = 0;
        end
    endtask

    task automatic goto_pos(input int target);
        int guard;
        guard = 0;
        while (pos != target && guard < 2 * FT) begin
            step();
            guard++;
        end
        n_checks++;
        if (pos !== target) $display("FAIL goto_pos: reached %0d, required %0d", pos, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({de, hs, vs, sof, eol, r, g, b, fc} !== {5'b01100, 24'h0, 16'h0})
            $display("FAIL reset_outputs: got de%b hs%b vs%b sof%b eol%b rgb=%h fc=%0d, required de0 hs1 vs1 sof0 eol0 rgb=000000 fc=0",
                     de, hs, vs, sof, eol, {r, g, b}, fc);
        else n_pass++;
        n_checks++;
        if ({p_hs, p_vs} !== 2'b00)
            $display("FAIL reset_pol_sync: got hs%b vs%b, required hs0 vs0", p_hs, p_vs);
        else n_pass++;
    endtask

    task automatic test_timing();
        int          p;
        logic [4:0]  t;
        logic [23:0] px;
        for (int k = 1; k <= FT; k++) begin
            p = pos;
            step();
            t  = exp_tim(p);
            px = exp_pix(p, 2'd0, 24'h123456);
            n_checks++;
            if ({de, hs, vs, sof, eol} !== {t[4], ~t[3], ~t[2], t[1], t[0]})
                $display("FAIL timing clk%0d: got de%b hs%b vs%b sof%b eol%b, required de%b hs%b vs%b sof%b eol%b",
                         k, de, hs, vs, sof, eol, t[4], ~t[3], ~t[2], t[1], t[0]);
            else n_pass++;
            n_checks++;
            if ({p_hs, p_vs} !== t[3:2])
                $display("FAIL pol_sync clk%0d: got hs%b vs%b, required hs%b vs%b", k, p_hs, p_vs, t[3], t[2]);
            else n_pass++;
            n_checks++;
            if ({r, g, b} !== px)
                $display("FAIL solid_pix clk%0d: got %h, required %h", k, {r, g, b}, px);
            else n_pass++;
        end
        n_checks++;
        if (fc !== 16'd1) $display("FAIL frame_cnt_98: got %0d, required 1", fc);
        else n_pass++;
    endtask

    task automatic test_bars();
        mode = 2'd1;
        goto_pos(0);
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({r, g, b} !== bars[i]) $display("FAIL bars px%0d: got %h, required %h", i, {r, g, b}, bars[i]);
            else n_pass++;
        end
    endtask

    task automatic test_frame_pattern(input logic [1:0] m);
        int          p;
        logic [23:0] px;
        mode = m;
        goto_pos(0);
        for (int k = 0; k < FT; k++) begin
            p = pos;
            step();
            px = exp_pix(p, m, solid);
            n_checks++;
            if ({r, g, b} !== px)
                $display("FAIL pattern m%0d pos%0d: got %h, required %h", m, p, {r, g, b}, px);
            else n_pass++;
        end
    endtask

    task automatic test_mode_switch();
        int          p;
        logic [23:0] px;
        mode  = 2'd0;
        solid = 24'hABCDEF;
        goto_pos(0);
        for (int k = 0; k < FT; k++) begin
            p = pos;
            if (p == 2 * HT) begin
                mode  = 2'd1;
                solid = 24'h111111;
            end
            step();
            px = exp_pix(p, 2'd0, 24'hABCDEF);
            n_checks++;
            if ({r, g, b} !== px)
                $display("FAIL switch_hold pos%0d: got %h, required %h", p, {r, g, b}, px);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({r, g, b} !== bars[i]) $display("FAIL switch_bars px%0d: got %h, required %h", i, {r, g, b}, bars[i]);
            else n_pass++;
        end
    endtask

    task automatic test_enable();
        int fc_hold;
        goto_pos(HT + 3);
        fc_hold = exp_fc;
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({de, hs, vs, sof, eol, r, g, b} !== {5'b01100, 24'h0})
                $display("FAIL en_low clk%0d: got de%b hs%b vs%b sof%b eol%b rgb=%h, required de0 hs1 vs1 sof0 eol0 rgb=000000",
                         k, de, hs, vs, sof, eol, {r, g, b});
            else n_pass++;
            n_checks++;
            if (fc !== 16'(fc_hold)) $display("FAIL en_low_fc clk%0d: got %0d, required %0d", k, fc, fc_hold);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_checks++;
        if ({sof, de} !== 2'b11) $display("FAIL en_restart: got sof%b de%b, required sof1 de1", sof, de);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        goto_pos(2 * HT + 3);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({de, hs, vs, sof, eol, r, g, b, fc} !== {5'b01100, 24'h0, 16'h0})
            $display("FAIL async_reset: got de%b hs%b vs%b sof%b eol%b rgb=%h fc=%0d, required de0 hs1 vs1 sof0 eol0 rgb=000000 fc=0",
                     de, hs, vs, sof, eol, {r, g, b}, fc);
        else n_pass++;
        n_checks++;
        if ({p_hs, p_vs, p_fc} !== {2'b00, 16'h0})
            $display("FAIL async_reset_pol: got hs%b vs%b fc=%0d, required hs0 vs0 fc=0", p_hs, p_vs, p_fc);
        else n_pass++;
        exp_fc = 0;
        pos    = 0;
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if ({sof, de, fc} !== {2'b11, 16'h0})
            $display("FAIL post_reset_sof: got sof%b de%b fc=%0d, required sof1 de1 fc=0", sof, de, fc);
        else n_pass++;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        solid = 24'h123456;
        #3;
        test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        pos = 0;
        test_timing();
        test_bars();
        test_frame_pattern(2'd2);
        test_frame_pattern(2'd3);
        test_mode_switch();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
